// File: rtl/vscale_scoreboard_ctrl_pkg.sv
// Shared constants for the vscale scoreboard hazard/bypass controller.
package vscale_scoreboard_ctrl_pkg;

    localparam int unsigned REG_ADDR_W    = 5;
    localparam int unsigned BYPASS_SEL_RF = 0;
    localparam int unsigned SB_LAT_ALU    = 1;
    localparam int unsigned SB_LAT_MEM    = 2;
    localparam int unsigned SB_LAT_MUL    = 3;

endpackage

// File: rtl/vscale_sb_lookup.sv
// Priority match of one source register against all in-flight entries.
module vscale_sb_lookup
    import vscale_scoreboard_ctrl_pkg::*;
#(
    parameter int unsigned STAGES    = 3,
    parameter int unsigned LAT_WIDTH = 3,
    parameter int unsigned SEL_WIDTH = 2
) (
    input  logic [REG_ADDR_W-1:0]          src_addr,
    input  logic                           src_used,
    input  logic [STAGES-1:0]              ent_valid,
    input  logic [REG_ADDR_W*STAGES-1:0]   ent_rd,
    input  logic [LAT_WIDTH*STAGES-1:0]    ent_lat,
    output logic                           hit,
    output logic [SEL_WIDTH-1:0]           sel,
    output logic                           hazard
);

    always_comb begin
        int unsigned k;
        hit    = 1'b0;
        sel    = SEL_WIDTH'(BYPASS_SEL_RF);
        hazard = 1'b0;
        k      = 0;
        // Scan oldest to youngest so the youngest matching writer wins.
        if (src_used && src_addr != '0) begin
            for (int unsigned j = 0; j < STAGES; j++) begin
                k = STAGES - j;
                if (ent_valid[k-1] && ent_rd[REG_ADDR_W*(k-1) +: REG_ADDR_W] == src_addr) begin
                    hit = 1'b1;
                    if (k >= 32'(ent_lat[LAT_WIDTH*(k-1) +: LAT_WIDTH])) begin
                        sel    = SEL_WIDTH'(k);
                        hazard = 1'b0;
                    end else begin
                        sel    = SEL_WIDTH'(BYPASS_SEL_RF);
                        hazard = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/vscale_scoreboard_ctrl.sv
// Parametrised scoreboard: tracks in-flight writers, drives bypass selects,
// issue stall, final-stage regfile write and a saturating stall counter.
module vscale_scoreboard_ctrl
    import vscale_scoreboard_ctrl_pkg::*;
#(
    parameter int unsigned STAGES    = 3,
    parameter int unsigned NUM_SRC   = 2,
    parameter int unsigned LAT_WIDTH = 3,
    parameter int unsigned SEL_WIDTH = 2,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           issue_valid,
    input  logic                           issue_wr,
    input  logic [4:0]                     issue_rd,
    input  logic [LAT_WIDTH-1:0]           issue_lat,
    input  logic [5*NUM_SRC-1:0]           src_addr,
    input  logic [NUM_SRC-1:0]             src_used,
    input  logic                           stall_back,
    input  logic                           flush,
    output logic                           issue_stall,
    output logic [SEL_WIDTH*NUM_SRC-1:0]   bypass_sel,
    output logic                           wb_valid,
    output logic [4:0]                     wb_rd,
    output logic                           busy,
    output logic [CNT_WIDTH-1:0]           stall_count
);

    logic [STAGES-1:0]              ent_valid;
    logic [REG_ADDR_W*STAGES-1:0]   ent_rd;
    logic [LAT_WIDTH*STAGES-1:0]    ent_lat;

    logic [NUM_SRC-1:0]             lk_hit;
    logic [NUM_SRC-1:0]             lk_haz;
    logic [SEL_WIDTH-1:0]           lk_sel [NUM_SRC];
    logic                           any_hazard;
    logic [LAT_WIDTH-1:0]           lat_norm;
    logic                           new_valid;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_lookup
        vscale_sb_lookup #(
            .STAGES    (STAGES),
            .LAT_WIDTH (LAT_WIDTH),
            .SEL_WIDTH (SEL_WIDTH)
        ) u_lookup (
            .src_addr  (src_addr[REG_ADDR_W*g +: REG_ADDR_W]),
            .src_used  (src_used[g]),
            .ent_valid (ent_valid),
            .ent_rd    (ent_rd),
            .ent_lat   (ent_lat),
            .hit       (lk_hit[g]),
            .sel       (lk_sel[g]),
            .hazard    (lk_haz[g])
        );

        assign bypass_sel[SEL_WIDTH*g +: SEL_WIDTH] =
            (lk_hit[g] && !lk_haz[g]) ? lk_sel[g] : SEL_WIDTH'(BYPASS_SEL_RF);
    end

    always_comb begin
        lat_norm = issue_lat;
        if (issue_lat == '0)
            lat_norm = LAT_WIDTH'(SB_LAT_ALU);
        else if (32'(issue_lat) > STAGES)
            lat_norm = LAT_WIDTH'(STAGES);
    end

    assign any_hazard  = |lk_haz;
    assign issue_stall = !flush && (stall_back || (issue_valid && any_hazard));
    assign new_valid   = issue_valid && !any_hazard && issue_wr && (issue_rd != '0);
    // Reset also masks the write so a mid-flight reset never leaks a regfile write.
    assign wb_valid    = ent_valid[STAGES-1] && !stall_back && !flush && !reset;
    assign wb_rd       = ent_rd[REG_ADDR_W*(STAGES-1) +: REG_ADDR_W];
    assign busy        = |ent_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_valid   <= '0;
            ent_rd      <= '0;
            ent_lat     <= '0;
            stall_count <= '0;
        end else begin
            if (issue_valid && issue_stall && stall_count != '1)
                stall_count <= stall_count + CNT_WIDTH'(1);
            if (flush) begin
                ent_valid <= '0;
            end else if (!stall_back) begin
                ent_valid <= {ent_valid[STAGES-2:0], new_valid};
                ent_rd    <= {ent_rd[REG_ADDR_W*(STAGES-1)-1:0], issue_rd};
                ent_lat   <= {ent_lat[LAT_WIDTH*(STAGES-1)-1:0], lat_norm};
            end
        end
    end

endmodule

// File: tb/tb_vscale_scoreboard_ctrl.sv
// Self-checking bench: directed pipeline scenarios plus randomized traffic
// checked every cycle against a list-of-instructions reference model.
module tb_vscale_scoreboard_ctrl;

    localparam int S    = 3;
    localparam int N    = 2;
    localparam int LW   = 3;
    localparam int SW   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              issue_valid;
    logic              issue_wr;
    logic [4:0]        issue_rd;
    logic [LW-1:0]     issue_lat;
    logic [5*N-1:0]    src_addr;
    logic [N-1:0]      src_used;
    logic              stall_back;
    logic              flush;
    logic              issue_stall;
    logic [SW*N-1:0]   bypass_sel;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic              busy;
    logic [CW-1:0]     stall_count;

    always #5 clk = ~clk;

    vscale_scoreboard_ctrl #(
        .STAGES    (S),
        .NUM_SRC   (N),
        .LAT_WIDTH (LW),
        .SEL_WIDTH (SW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_wr    (issue_wr),
        .issue_rd    (issue_rd),
        .issue_lat   (issue_lat),
        .src_addr    (src_addr),
        .src_used    (src_used),
        .stall_back  (stall_back),
        .flush       (flush),
        .issue_stall (issue_stall),
        .bypass_sel  (bypass_sel),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .busy        (busy),
        .stall_count (stall_count)
    );

    // Reference: in-flight instructions indexed by age (stages past issue).
    typedef struct {
        bit v;
        int rd;
        int lat;
    } inst_t;

    inst_t m [1:S];
    int    m_cnt = 0;
    bit    m_live = 1'b0;
    int    n_cmp = 0;
    int    n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int k = 1; k <= S; k++) m[k] = '{v: 1'b0, rd: 0, lat: 0};
    endfunction

    function automatic void model_lookup(output logic [SW*N-1:0] sel, output bit haz);
        int a;
        sel = '0;
        haz = 1'b0;
        for (int i = 0; i < N; i++) begin
            a = int'(src_addr[5*i +: 5]);
            if (src_used[i] && a != 0) begin
                for (int k = 1; k <= S; k++) begin
                    if (m[k].v && m[k].rd == a) begin
                        if (k >= m[k].lat) sel[SW*i +: SW] = SW'(k);
                        else               haz = 1'b1;
                        break;
                    end
                end
            end
        end
    endfunction

    always @(posedge clk) begin
        logic [SW*N-1:0] s;
        bit h, st;
        int lat;
        if (reset) begin
            model_clear();
            m_cnt  = 0;
            m_live = 1'b1;
        end else if (m_live) begin
            model_lookup(s, h);
            st = !flush && (stall_back || (issue_valid && h));
            if (issue_valid && st && m_cnt < CMAX) m_cnt++;
            if (flush) begin
                model_clear();
            end else if (!stall_back) begin
                for (int k = S; k >= 2; k--) m[k] = m[k-1];
                lat = int'(issue_lat);
                if (lat == 0) lat = 1;
                if (lat > S)  lat = S;
                m[1] = '{v: issue_valid && !h && issue_wr && issue_rd != 0, rd: int'(issue_rd), lat: lat};
            end
        end
    end

    always @(negedge clk) begin
        logic [SW*N-1:0] s;
        bit h, st, wv;
        bit any_v;
        if (m_live) begin
            model_lookup(s, h);
            st    = !flush && (stall_back || (issue_valid && h));
            wv    = m[S].v && !stall_back && !flush && !reset;
            any_v = 1'b0;
            for (int k = 1; k <= S; k++) any_v |= m[k].v;
            chk("issue_stall", 64'(issue_stall), 64'(st));
            chk("bypass_sel",  64'(bypass_sel),  64'(s));
            chk("wb_valid",    64'(wb_valid),    64'(wv));
            if (wv) chk("wb_rd", 64'(wb_rd), 64'(m[S].rd));
            chk("busy",        64'(busy),        64'(any_v));
            chk("stall_count", 64'(stall_count), 64'(m_cnt));
        end
    end

    task automatic set(input bit iv, input bit wr, input int rd, input int lat,
                       input int s0, input bit u0, input int s1, input bit u1,
                       input bit sb, input bit fl, input bit rs);
        issue_valid = iv;
        issue_wr    = wr;
        issue_rd    = 5'(rd);
        issue_lat   = LW'(lat);
        src_addr    = {5'(s1), 5'(s0)};
        src_used    = {u1, u0};
        stall_back  = sb;
        flush       = fl;
        reset       = rs;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        adv();

        // Reset state
        idle();
        chk("rst_busy", 64'(busy), 0);
        chk("rst_wb_valid", 64'(wb_valid), 0);
        chk("rst_bypass", 64'(bypass_sel), 0);
        chk("rst_count", 64'(stall_count), 0);
        chk("rst_stall", 64'(issue_stall), 0);
        adv();
        set(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("rst_stall_back", 64'(issue_stall), 1);
        adv();

        // ALU producer x5 then consumers at stage 1 and 2
        set(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("alu_issue_stall", 64'(issue_stall), 0);
        adv();
        set(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        chk("alu_sel1", 64'(bypass_sel[1:0]), 1);
        chk("alu_nostall", 64'(issue_stall), 0);
        adv();
        set(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        chk("alu_sel2", 64'(bypass_sel[1:0]), 2);
        adv();

        // Load-use x6
        set(1, 1, 6, 2, 0, 0, 0, 0, 0, 0, 0);
        chk("wb_x5_valid", 64'(wb_valid), 1);
        chk("wb_x5_rd", 64'(wb_rd), 5);
        adv();
        set(1, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0);
        chk("load_use_stall", 64'(issue_stall), 1);
        adv();
        set(1, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0);
        chk("load_release", 64'(issue_stall), 0);
        chk("load_sel2", 64'(bypass_sel[1:0]), 2);
        chk("load_count", 64'(stall_count), 1);
        adv();

        // Mul x7, consumer on operand 1
        set(1, 1, 7, 3, 0, 0, 0, 0, 0, 0, 0);
        adv();
        set(1, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        chk("mul_stall1", 64'(issue_stall), 1);
        adv();
        set(1, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        chk("mul_stall2", 64'(issue_stall), 1);
        adv();
        set(1, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        chk("mul_release", 64'(issue_stall), 0);
        chk("mul_sel3", 64'(bypass_sel[3:2]), 3);
        chk("mul_wb_valid", 64'(wb_valid), 1);
        chk("mul_wb_rd", 64'(wb_rd), 7);
        chk("mul_count", 64'(stall_count), 3);
        adv();

        // Two writers to x8: youngest wins; unused operand ignored
        set(1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
        adv();
        set(1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
        adv();
        set(1, 0, 0, 0, 8, 1, 8, 0, 0, 0, 0);
        chk("x8_youngest", 64'(bypass_sel), 1);
        adv();

        // Writes to x0 never create hazards
        set(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        adv();
        set(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        chk("x0_nostall", 64'(issue_stall), 0);
        chk("x0_sel", 64'(bypass_sel), 0);
        adv();

        // Flush with three valid entries
        for (int r = 9; r <= 11; r++) begin
            set(1, 1, r, 1, 0, 0, 0, 0, 0, 0, 0);
            adv();
        end
        set(1, 1, 12, 1, 0, 0, 0, 0, 0, 1, 0);
        chk("flush_stall", 64'(issue_stall), 0);
        chk("flush_wb", 64'(wb_valid), 0);
        adv();
        idle();
        chk("flush_busy", 64'(busy), 0);
        chk("flush_count", 64'(stall_count), 3);
        adv();

        // Backend stall freezes three entries for four cycles
        for (int r = 12; r <= 14; r++) begin
            set(1, 1, r, 1, 0, 0, 0, 0, 0, 0, 0);
            adv();
        end
        for (int c = 0; c < 4; c++) begin
            set(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            chk("sb_stall", 64'(issue_stall), 1);
            chk("sb_wb", 64'(wb_valid), 0);
            adv();
        end
        for (int r = 12; r <= 14; r++) begin
            idle();
            chk("sb_resume_valid", 64'(wb_valid), 1);
            chk("sb_resume_rd", 64'(wb_rd), 64'(r));
            if (r == 12) chk("sb_count", 64'(stall_count), 7);
            adv();
        end

        // Saturation of the narrow counter
        for (int c = 0; c < 10; c++) begin
            set(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            adv();
        end
        idle();
        chk("sat_count", 64'(stall_count), 64'(CMAX));
        adv();

        // Randomized traffic, checked by the per-cycle compare process
        for (int c = 0; c < 4000; c++) begin
            set($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
                $urandom_range(0, 199) == 0);
            adv();
        end

        idle();
        adv();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
